// File: rtl/ic_fill_ctrl.sv
// Instruction-cache refill controller.
// Issues one burst per miss, writes returned words into the cache data array,
// holds off line replacement while a line is partially written, and drains
// the owed burst when a flush/redirect arrives mid-fill.
// Optional build macro ICF_CRIT_WORD_FIRST_EN: critical-word-first wrap-order
// burst with an early-restart pulse on the first written beat.
module ic_fill_ctrl #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           miss_i,
  input  logic [ADDR_W-1:0]              miss_addr_i,
  input  logic                           flush_i,
  output logic                           mem_req_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [31:0]                    mem_rdata_i,
  output logic                           fill_we_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx_o,
  output logic [31:0]                    fill_data_o,
  output logic [ADDR_W-1:0]              fill_tag_addr_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           crit_valid_o,
  output logic                           ic_repl_permit_o
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam logic [ADDR_W-1:0] BLK_MASK = {ADDR_W{1'b1}} << (IDX_W + 2);
`ifdef ICF_CRIT_WORD_FIRST_EN
  // Keep the word offset: the burst starts at the missing word.
  localparam logic [ADDR_W-1:0] LATCH_MASK = {ADDR_W{1'b1}} << 2;
`else
  localparam logic [ADDR_W-1:0] LATCH_MASK = BLK_MASK;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    BEAT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;   // word index of the next beat
  logic [IDX_W-1:0]  cnt_q, cnt_d;   // beats consumed so far in this burst
  logic [IDX_W-1:0]  start_idx;
  logic              beat_last;

`ifdef ICF_CRIT_WORD_FIRST_EN
  assign start_idx = addr_q[IDX_W+1:2];
`else
  assign start_idx = '0;
`endif

  assign beat_last = (cnt_q == IDX_W'(BLOCK_WORDS - 1));

  // Next-state, address latch and beat bookkeeping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // A miss coinciding with a flush belongs to the squashed path.
        if (miss_i && !flush_i) begin
          addr_d  = miss_addr_i & LATCH_MASK;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          idx_d   = start_idx;
          cnt_d   = '0;
          // Once granted, the full burst is owed even if fetch redirected.
          state_d = flush_i ? DRAIN : BEAT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      BEAT: begin
        if (mem_rvalid_i) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = cnt_q + IDX_W'(1);
          if (beat_last) begin
            state_d = flush_i ? IDLE : DONE;
          end else if (flush_i) begin
            state_d = DRAIN;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = cnt_q + IDX_W'(1);
          if (beat_last) begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        // Fetch re-presents any miss once we are back in IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req_o        = (state_q == REQ);
  assign mem_addr_o       = addr_q;
  assign fill_tag_addr_o  = addr_q & BLK_MASK;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);
  assign ic_repl_permit_o = (state_q == IDLE) || (state_q == DONE);

  // A beat that arrives with a flush is consumed but never written.
  assign fill_we_o   = (state_q == BEAT) && mem_rvalid_i && !flush_i;
  assign fill_idx_o  = idx_q;
  assign fill_data_o = mem_rdata_i;

`ifdef ICF_CRIT_WORD_FIRST_EN
  assign crit_valid_o = fill_we_o && (cnt_q == '0);
`else
  assign crit_valid_o = done_o;
`endif

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Self-checking bench for ic_fill_ctrl: randomized misses, grants, beat gaps
// and flushes; expected writes, requests, completions and critical-word
// pulses are queued by a block-level model and checked by a monitor.
module tb_ic_fill_ctrl;

  localparam int BW = 4;
  localparam int AW = 32;
  localparam int IW = $clog2(BW);
`ifdef ICF_CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk;
  logic          rst_n_i;
  logic          miss_i;
  logic [AW-1:0] miss_addr_i;
  logic          flush_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic          fill_we_o;
  logic [IW-1:0] fill_idx_o;
  logic [31:0]   fill_data_o;
  logic [AW-1:0] fill_tag_addr_o;
  logic          busy_o;
  logic          done_o;
  logic          crit_valid_o;
  logic          ic_repl_permit_o;

  ic_fill_ctrl #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n_i),
    .miss_i          (miss_i),
    .miss_addr_i     (miss_addr_i),
    .flush_i         (flush_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .fill_we_o       (fill_we_o),
    .fill_idx_o      (fill_idx_o),
    .fill_data_o     (fill_data_o),
    .fill_tag_addr_o (fill_tag_addr_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .crit_valid_o    (crit_valid_o),
    .ic_repl_permit_o(ic_repl_permit_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] tag;
  } req_t;
  typedef struct {
    int          idx;
    logic [31:0] data;
  } wr_t;

  req_t          req_q[$];
  wr_t           wr_q[$];
  logic [AW-1:0] done_q[$];
  int            crit_q[$];   // -1: pulse expected with done_o, else word index

  // Block-level model of where a miss lands.
  function automatic logic [AW-1:0] blk_base(input logic [AW-1:0] a);
    return a & ~(AW'(BW * 4 - 1));
  endfunction
  function automatic logic [AW-1:0] req_addr(input logic [AW-1:0] a);
    return CWF ? (a & ~(AW'(3))) : blk_base(a);
  endfunction
  function automatic int start_of(input logic [AW-1:0] a);
    return CWF ? int'((a >> 2) % BW) : 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=1 expected=0", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_mem_req"}, 64'(mem_req_o), 64'(0));
    chk({tag, "_fill_we"}, 64'(fill_we_o), 64'(0));
    chk({tag, "_done"}, 64'(done_o), 64'(0));
    chk({tag, "_crit"}, 64'(crit_valid_o), 64'(0));
    chk({tag, "_busy"}, 64'(busy_o), 64'(0));
    chk({tag, "_permit"}, 64'(ic_repl_permit_o), 64'(1));
    chk({tag, "_mem_addr"}, 64'(mem_addr_o), 64'(0));
    chk({tag, "_tag_addr"}, 64'(fill_tag_addr_o), 64'(0));
    chk({tag, "_fill_idx"}, 64'(fill_idx_o), 64'(0));
  endtask

  // Monitor: compares DUT events against the queued expectations.
  initial begin
    wr_t           e;
    int            c;
    logic [AW-1:0] t;
    forever begin
      @(negedge clk);
      if (rst_n_i) begin
        if (mem_req_o) begin
          if (req_q.size() == 0) unexp("req_unexpected");
          else begin
            chk("mem_addr", 64'(mem_addr_o), 64'(req_q[0].addr));
            chk("tag_addr_req", 64'(fill_tag_addr_o), 64'(req_q[0].tag));
            if (mem_gnt_i || flush_i) void'(req_q.pop_front());
          end
        end
        if (crit_valid_o) begin
          if (crit_q.size() == 0) unexp("crit_unexpected");
          else begin
            c = crit_q.pop_front();
            if (c < 0) chk("crit_with_done", 64'(done_o), 64'(1));
            else begin
              chk("crit_we", 64'(fill_we_o), 64'(1));
              chk("crit_idx", 64'(fill_idx_o), 64'(c));
            end
          end
        end
        if (fill_we_o) begin
          if (wr_q.size() == 0) unexp("write_unexpected");
          else begin
            e = wr_q.pop_front();
            chk("fill_idx", 64'(fill_idx_o), 64'(e.idx));
            chk("fill_data", 64'(fill_data_o), 64'(e.data));
          end
          chk("permit_during_write", 64'(ic_repl_permit_o), 64'(0));
        end
        if (done_o) begin
          if (done_q.size() == 0) unexp("done_unexpected");
          else begin
            t = done_q.pop_front();
            chk("done_tag_addr", 64'(fill_tag_addr_o), 64'(t));
          end
          chk("permit_done", 64'(ic_repl_permit_o), 64'(1));
          chk("busy_done", 64'(busy_o), 64'(1));
        end
      end
    end
  end

  // mode 0: clean fill, 1: flush in BEAT before/with beat flush_k,
  // 2: flush in REQ without grant, 3: flush in REQ together with grant.
  task automatic do_fill(input logic [AW-1:0] addr, input int mode, input int flush_k,
                         input bit flush_w_beat, input int gdelay);
    int          g, gap, written, st;
    logic [31:0] d;
    bit          fl_gap;
    st      = start_of(addr);
    written = (mode == 0) ? BW : ((mode == 1) ? flush_k : 0);
    miss_i      = 1'b1;
    miss_addr_i = addr;
    flush_i     = 1'b0;
    req_q.push_back('{req_addr(addr), blk_base(addr)});
    step();
    miss_i      = 1'b0;
    miss_addr_i = $urandom;
    chk("busy_req", 64'(busy_o), 64'(1));
    chk("permit_req", 64'(ic_repl_permit_o), 64'(0));
    g = (gdelay < 0) ? int'($urandom_range(0, 3)) : gdelay;
    for (int i = 0; i < g; i++) begin
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_rdata_i  = $urandom;
      step();
    end
    mem_rvalid_i = 1'b0;
    if (mode == 2) begin
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("busy_after_req_flush", 64'(busy_o), 64'(0));
      chk("req_after_req_flush", 64'(mem_req_o), 64'(0));
      return;
    end
    mem_gnt_i = 1'b1;
    flush_i   = (mode == 3);
    step();
    mem_gnt_i = 1'b0;
    flush_i   = 1'b0;
    for (int k = 0; k < BW; k++) begin
      gap    = int'($urandom_range(0, 2));
      fl_gap = (mode == 1) && (k == flush_k) && !flush_w_beat;
      if (fl_gap && gap == 0) gap = 1;
      for (int j = 0; j < gap; j++) begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        flush_i      = fl_gap && (j == 0);
        step();
      end
      chk("busy_beat", 64'(busy_o), 64'(1));
      chk("permit_beat", 64'(ic_repl_permit_o), 64'(0));
      flush_i      = (mode == 1) && (k == flush_k) && flush_w_beat;
      d            = $urandom;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = d;
      if (k < written) begin
        wr_q.push_back('{(st + k) % BW, d});
        if (CWF && k == 0) crit_q.push_back(st);
      end
      step();
      mem_rvalid_i = 1'b0;
      flush_i      = 1'b0;
    end
    if (written == BW) begin
      done_q.push_back(blk_base(addr));
      if (!CWF) crit_q.push_back(-1);
      miss_i      = 1'($urandom_range(0, 1));
      miss_addr_i = $urandom;
      step();
      miss_i = 1'b0;
    end
    chk("busy_idle", 64'(busy_o), 64'(0));
    chk("permit_idle", 64'(ic_repl_permit_o), 64'(1));
    chk("req_idle", 64'(mem_req_o), 64'(0));
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            m;
    rst_n_i      = 1'b0;
    miss_i       = 1'b0;
    miss_addr_i  = '0;
    flush_i      = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst0");
    rst_n_i = 1'b1;
    step();

    // Directed cases.
    do_fill(32'h0000_1234, 0, 0, 1'b0, 2);
    do_fill(32'h0000_1238, 0, 0, 1'b0, 0);
    do_fill(32'h0000_2200, 1, 1, 1'b1, 1);
    do_fill(32'h0000_2204, 1, 0, 1'b0, 1);
    do_fill(32'h0000_223c, 1, BW - 1, 1'b1, 0);
    do_fill(32'h0000_3000, 2, 0, 1'b0, 1);
    do_fill(32'h0000_3010, 3, 0, 1'b0, 0);

    // Miss together with flush in IDLE is dropped.
    miss_i      = 1'b1;
    flush_i     = 1'b1;
    miss_addr_i = 32'h0000_4444;
    step();
    miss_i  = 1'b0;
    flush_i = 1'b0;
    chk("miss_flush_busy", 64'(busy_o), 64'(0));
    chk("miss_flush_req", 64'(mem_req_o), 64'(0));

    // Asynchronous reset in the middle of a burst.
    a           = 32'hABCD_5678;
    miss_i      = 1'b1;
    miss_addr_i = a;
    req_q.push_back('{req_addr(a), blk_base(a)});
    step();
    miss_i    = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i    = 1'b0;
    d            = $urandom;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    wr_q.push_back('{start_of(a), d});
    if (CWF) crit_q.push_back(start_of(a));
    step();
    mem_rdata_i = $urandom;
    #2 rst_n_i = 1'b0;
    #1;
    reset_checks("rst_mid");
    step();
    step();
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = $urandom;
      step();
      chk("stray_beat_busy", 64'(busy_o), 64'(0));
    end
    mem_rvalid_i = 1'b0;
    do_fill(32'h0000_5554, 0, 0, 1'b0, -1);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      m = int'($urandom_range(0, 9));
      if (m == 9) begin
        miss_i      = 1'b1;
        flush_i     = 1'b1;
        miss_addr_i = a;
        step();
        miss_i  = 1'b0;
        flush_i = 1'b0;
        chk("rand_miss_flush_busy", 64'(busy_o), 64'(0));
      end else begin
        do_fill(a, (m <= 4) ? 0 : (m <= 6) ? 1 : (m == 7) ? 2 : 3,
                int'($urandom_range(0, BW - 1)), 1'($urandom_range(0, 1)), -1);
      end
    end

    repeat (3) step();
    chk("wr_q_empty", 64'(wr_q.size()), 64'(0));
    chk("done_q_empty", 64'(done_q.size()), 64'(0));
    chk("crit_q_empty", 64'(crit_q.size()), 64'(0));
    chk("req_q_empty", 64'(req_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ic_fill_ctrl.md
Name: ic_fill_ctrl

Overview:
Instruction-cache refill controller between the fetch-side miss detector and the backing instruction memory. On a miss it issues one burst request for the missing block, then writes each returned word into the cache data array. It gates cache line replacement while a fill is in progress and signals completion so fetch can resume. It also handles flush or redirect during a fill by draining the in-flight burst.

Parameters:
- BLOCK_WORDS, 4, 32-bit words per cache block; power of two, >= 2
- ADDR_W, 32, byte address width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- miss_i  in  1  fetch miss; sampled only in IDLE
- miss_addr_i  in  ADDR_W  byte address of the missing instruction
- flush_i  in  1  pipeline flush/redirect; abandons the current fill
- mem_req_o  out  1  burst request to backing memory
- mem_addr_o  out  ADDR_W  burst start byte address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  return beat valid
- mem_rdata_i  in  32  return beat data
- fill_we_o  out  1  cache data-array write enable
- fill_idx_o  out  clog2(BLOCK_WORDS)  word index within the block for the write
- fill_data_o  out  32  write data
- fill_tag_addr_o  out  ADDR_W  block-aligned address of the line being filled
- busy_o  out  1  fill in progress
- done_o  out  1  one-cycle fill-complete pulse
- crit_valid_o  out  1  one-cycle pulse: missing word is available
- ic_repl_permit_o  out  1  replacement/victim state may update

Behaviour:
- States: IDLE, REQ, BEAT, DRAIN, DONE. Reset enters IDLE.
- Reset values:
  - mem_req_o, fill_we_o, done_o, crit_valid_o, busy_o = 0
  - ic_repl_permit_o = 1
  - mem_addr_o, fill_tag_addr_o, beat counter = 0
- IDLE:
  - miss_i=1 && flush_i=0: latch miss_addr_i, go to REQ next cycle.
  - miss_i with flush_i in the same cycle is ignored.
- REQ:
  - mem_req_o=1; mem_addr_o is held stable until grant.
  - mem_gnt_i=1: go to BEAT; counter = start index.
  - flush_i=1 && mem_gnt_i=0: go to IDLE; no request was accepted.
  - flush_i=1 && mem_gnt_i=1: go to DRAIN, because the burst is now owed.
  - mem_rvalid_i in REQ is ignored.
- BEAT:
  - Each mem_rvalid_i beat: fill_we_o=1 combinationally, fill_data_o=mem_rdata_i, fill_idx_o=counter.
  - Counter increments mod BLOCK_WORDS on every beat.
  - After the BLOCK_WORDS-th beat, go to DONE.
  - Beats may have gaps; there is no timeout.
- DRAIN:
  - Entered on flush_i in BEAT, or on flush with grant in REQ.
  - Remaining beats are consumed with fill_we_o=0.
  - After the last beat, go to IDLE; no done_o.
  - flush_i in BEAT on the same cycle as a beat: that beat is not written; it counts toward the drain.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - miss_i in DONE is ignored; fetch re-presents it in IDLE.
- busy_o = (state != IDLE).
- ic_repl_permit_o = 1 only in IDLE and DONE; 0 while a line is partially written.
- fill_tag_addr_o = latched address with the low clog2(BLOCK_WORDS)+2 bits cleared; stable from REQ through DONE.
- Beat count = BLOCK_WORDS per granted request, independent of flush.
- Reset mid-fill returns to IDLE immediately. The backing memory must also be reset; in-flight beats after reset are ignored in IDLE.

Optional Feature:
ICF_CRIT_WORD_FIRST_EN
- Defined:
  - mem_addr_o = word-aligned miss address (low 2 bits cleared).
  - Memory returns beats in wrap order.
  - Counter starts at the miss word index and wraps mod BLOCK_WORDS.
  - crit_valid_o pulses on the first written beat, enabling early restart.
  - In DRAIN, no crit_valid_o.
- Undefined:
  - mem_addr_o is block-aligned; counter starts at 0.
  - crit_valid_o pulses together with done_o.

Test Plan:
- Basic fill, BLOCK_WORDS=4: miss_addr 0x0000_1234, grant after 2 cycles, 4 consecutive beats D0..D3 -> mem_addr 0x0000_1230, writes idx 0,1,2,3 with D0..D3, done_o one cycle after the 4th beat, ic_repl_permit_o=0 from REQ to the last beat.
- Gapped beats: beats on cycles 0, 3, 4, 9 after grant -> fill_we_o high only on those cycles; done_o on cycle 10.
- Flush during BEAT after 1 beat -> the remaining 3 beats give fill_we_o=0, no done_o, busy_o drops after the 4th beat; ic_repl_permit_o returns to 1.
- Flush in REQ: without grant -> IDLE next cycle, mem_req_o drops; with grant the same cycle -> DRAIN consumes 4 beats.
- CWF (macro on): miss_addr 0x0000_1238 -> mem_addr 0x0000_1238, idx order 2,3,0,1, crit_valid_o on the first beat only.
- Async reset asserted mid-BEAT -> all outputs at reset values without a clock edge; a later miss fills normally.
